// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: grants one of icache/dcache at a time, dcache priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound icache wait to STARVE_LIMIT dcache grants.
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic                       DUT_error,
    input  logic                       imem_REN,
    input  logic [ADDR_W-1:0]          imem_block_addr,
    output logic                       imem_hit,
    output logic [1:0][DATA_W-1:0]     imem_load,
    input  logic                       dmem_REN,
    input  logic                       dmem_WEN,
    input  logic [ADDR_W-1:0]          dmem_block_addr,
    input  logic [1:0][DATA_W-1:0]     dmem_store,
    output logic                       dmem_hit,
    output logic [1:0][DATA_W-1:0]     dmem_load,
    output logic                       mem_REN,
    output logic                       mem_WEN,
    output logic [ADDR_W-1:0]          mem_block_addr,
    output logic [1:0][DATA_W-1:0]     mem_store,
    input  logic                       mem_hit,
    input  logic [1:0][DATA_W-1:0]     mem_load
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t state, state_nxt;
    logic   dreq;
    logic   starve_fire;

    assign dreq = dmem_REN | dmem_WEN;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    // Counts dcache grants the icache had to watch; an icache grant clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (state_nxt == IGNT)
                starve_cnt <= '0;
            else if (state_nxt == DGNT && imem_REN)
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

    assign starve_fire = imem_REN && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign starve_fire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) DUT_error <= 1'b0;
        else       DUT_error <= dmem_REN & dmem_WEN;
    end

    // Granted request is forwarded live so an abort drops mem_REN/WEN the same cycle.
    always_comb begin
        state_nxt      = state;
        mem_REN        = 1'b0;
        mem_WEN        = 1'b0;
        mem_block_addr = '0;
        mem_store      = '0;
        imem_hit       = 1'b0;
        imem_load      = '0;
        dmem_hit       = 1'b0;
        dmem_load      = '0;
        case (state)
            IDLE: begin
                if (dreq && !starve_fire) state_nxt = DGNT;
                else if (imem_REN)        state_nxt = IGNT;
            end
            IGNT: begin
                mem_REN        = imem_REN;
                mem_block_addr = imem_block_addr;
                imem_hit       = mem_hit;
                if (mem_hit) imem_load = mem_load;
                if (mem_hit || !imem_REN) state_nxt = IDLE;
            end
            DGNT: begin
                mem_REN        = dmem_REN;
                mem_WEN        = dmem_WEN;
                mem_block_addr = dmem_block_addr;
                mem_store      = dmem_store;
                dmem_hit       = mem_hit;
                if (mem_hit) dmem_load = mem_load;
                if (mem_hit || !dreq) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level owner model predicts each
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int NONE = 0, OWN_I = 1, OWN_D = 2;

    logic                 CLK, nRST, DUT_error;
    logic                 imem_REN, imem_hit;
    logic [AW-1:0]        imem_block_addr;
    logic [1:0][DW-1:0]   imem_load;
    logic                 dmem_REN, dmem_WEN, dmem_hit;
    logic [AW-1:0]        dmem_block_addr;
    logic [1:0][DW-1:0]   dmem_store, dmem_load;
    logic                 mem_REN, mem_WEN, mem_hit;
    logic [AW-1:0]        mem_block_addr;
    logic [1:0][DW-1:0]   mem_store, mem_load;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST), .DUT_error(DUT_error),
        .imem_REN(imem_REN), .imem_block_addr(imem_block_addr),
        .imem_hit(imem_hit), .imem_load(imem_load),
        .dmem_REN(dmem_REN), .dmem_WEN(dmem_WEN), .dmem_block_addr(dmem_block_addr),
        .dmem_store(dmem_store), .dmem_hit(dmem_hit), .dmem_load(dmem_load),
        .mem_REN(mem_REN), .mem_WEN(mem_WEN), .mem_block_addr(mem_block_addr),
        .mem_store(mem_store), .mem_hit(mem_hit), .mem_load(mem_load)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic               mren;
        logic               mwen;
        logic [AW-1:0]      addr;
        logic [1:0][DW-1:0] store;
        logic               ihit;
        logic [1:0][DW-1:0] iload;
        logic               dhit;
        logic [1:0][DW-1:0] dload;
        logic               err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state: who owns memory, for how long, and the starvation tally
    int   m_owner = NONE;
    int   m_age = 0;
    int   m_lat = 1;
    int   m_cnt = 0;
    bit   m_both_prev = 1'b0;
    int   lat_fix = 0;
    bit   stray_en = 1'b0;
    bit   last_ihit, last_dhit, obs_ihit, obs_dhit;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mem_req", 128'({mem_REN, mem_WEN, mem_block_addr, mem_store}),
                  128'({e.mren, e.mwen, e.addr, e.store}));
            check("imem_rsp", 128'({imem_hit, imem_load}), 128'({e.ihit, e.iload}));
            check("dmem_rsp", 128'({dmem_hit, dmem_load}), 128'({e.dhit, e.dload}));
            check("dut_error", 128'(DUT_error), 128'(e.err));
        end
    end

    // Predict this cycle's outputs from the live inputs, advance the model, step one clock.
    task automatic cycle();
        exp_t e;
        bool_req_t: begin end
        e = '0;
        if (nRST) begin
            e.err = m_both_prev;
            if (m_owner == OWN_I) begin
                e.mren = imem_REN;
                e.addr = imem_block_addr;
                if (mem_hit) begin e.ihit = 1'b1; e.iload = mem_load; end
            end else if (m_owner == OWN_D) begin
                e.mren  = dmem_REN;
                e.mwen  = dmem_WEN;
                e.addr  = dmem_block_addr;
                e.store = dmem_store;
                if (mem_hit) begin e.dhit = 1'b1; e.dload = mem_load; end
            end
        end
        sb.push_back(e);
        last_ihit = e.ihit;
        last_dhit = e.dhit;
        if (!nRST) begin
            m_owner = NONE; m_cnt = 0; m_both_prev = 1'b0;
        end else begin
            m_both_prev = dmem_REN & dmem_WEN;
            if (m_owner == NONE) begin
                if ((dmem_REN | dmem_WEN) && !(GUARD && imem_REN && m_cnt == LIMIT)) begin
                    m_owner = OWN_D;
                    if (imem_REN && m_cnt < LIMIT) m_cnt++;
                end else if (imem_REN) begin
                    m_owner = OWN_I;
                    m_cnt = 0;
                end
                m_age = 0;
                m_lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            end else if (mem_hit || !(m_owner == OWN_I ? imem_REN : (dmem_REN | dmem_WEN))) begin
                m_owner = NONE;
            end else begin
                m_age++;
            end
        end
        @(negedge CLK);
        obs_ihit = imem_hit;
        obs_dhit = dmem_hit;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_mem();
        mem_load = {$urandom(), $urandom()};
        if (m_owner != NONE) mem_hit = (m_age >= m_lat - 1);
        else                 mem_hit = stray_en && ($urandom_range(0, 7) == 0);
    endtask

    task automatic idle_inputs();
        imem_REN = 0; imem_block_addr = '0;
        dmem_REN = 0; dmem_WEN = 0; dmem_block_addr = '0; dmem_store = '0;
        mem_hit = 0; mem_load = '0;
    endtask

    initial begin
        int dn, dcount;
        bit got_i, d_on, i_on, w;
        nRST = 1'b0;
        idle_inputs();
        @(posedge CLK);
        #1;
        cycle(); cycle();
        nRST = 1'b1;

        // icache-only read
        imem_REN = 1; imem_block_addr = AW'('h10);
        cycle(); cycle();
        mem_hit = 1; mem_load[1] = 'hA; mem_load[0] = 'hB;
        cycle();
        idle_inputs(); cycle();

        // contention: dcache first, bubble, then icache
        imem_REN = 1; imem_block_addr = AW'('h11);
        dmem_REN = 1; dmem_block_addr = AW'('h20);
        cycle(); cycle();
        mem_hit = 1; mem_load = {32'h1111, 32'h2222}; cycle();
        mem_hit = 0; dmem_REN = 0; cycle(); cycle();
        mem_hit = 1; mem_load = {32'h3333, 32'h4444}; cycle();
        idle_inputs(); cycle();

        // dcache write
        dmem_WEN = 1; dmem_block_addr = AW'('h3F); dmem_store = {32'd1, 32'd2};
        cycle(); cycle();
        mem_hit = 1; mem_load = {32'h5555, 32'h6666}; cycle();
        idle_inputs(); cycle();

        // icache abort, then a stray hit
        imem_REN = 1; imem_block_addr = AW'('h22);
        cycle(); cycle();
        imem_REN = 0; cycle();
        mem_hit = 1; mem_load = {32'h7777, 32'h8888}; cycle();
        idle_inputs(); cycle();

        // protocol error
        dmem_REN = 1; dmem_WEN = 1; dmem_block_addr = AW'('h5);
        cycle();
        idle_inputs(); cycle(); cycle();

        // reset in the middle of a dcache grant
        dmem_REN = 1; dmem_block_addr = AW'('h6);
        cycle(); cycle();
        mem_hit = 1; mem_load = {32'h9999, 32'hAAAA}; nRST = 0; cycle();
        mem_hit = 0; nRST = 1; cycle(); cycle();
        idle_inputs(); cycle();

        // starvation: continuous dcache, pending icache, memory latency 2
        nRST = 0; cycle(); nRST = 1;
        lat_fix = 2;
        imem_REN = 1; imem_block_addr = AW'('h55);
        dn = 0; dcount = 0; got_i = 0;
        for (int c = 0; c < 80 && !got_i; c++) begin
            dmem_REN = (dn < 8);
            dmem_block_addr = AW'(dn);
            drive_mem();
            cycle();
            if (last_dhit) dn++;
            if (obs_dhit) dcount++;
            if (obs_ihit) got_i = 1;
            if (last_ihit) imem_REN = 0;
        end
        check("starve_igrant", 128'(got_i), 128'(1));
        check("starve_dtxns", 128'(dcount), GUARD ? 128'(LIMIT) : 128'(8));
        idle_inputs(); cycle();

        // randomized traffic with aborts, variable latency and stray hits
        lat_fix = 0; stray_en = 1; i_on = 0; d_on = 0;
        for (int c = 0; c < 1500; c++) begin
            if (i_on && (last_ihit || (m_owner == OWN_I && $urandom_range(0, 15) == 0))) begin
                i_on = 0;
            end else if (!i_on && $urandom_range(0, 2) == 0) begin
                i_on = 1; imem_block_addr = AW'($urandom());
            end
            imem_REN = i_on;
            if (d_on && (last_dhit || (m_owner == OWN_D && $urandom_range(0, 15) == 0))) begin
                d_on = 0; dmem_REN = 0; dmem_WEN = 0;
            end else if (!d_on && $urandom_range(0, 3) == 0) begin
                d_on = 1; w = 1'($urandom_range(0, 1));
                dmem_REN = !w; dmem_WEN = w;
                dmem_block_addr = AW'($urandom());
                dmem_store = {$urandom(), $urandom()};
            end
            drive_mem();
            cycle();
        end
        stray_en = 0;
        idle_inputs(); cycle(); cycle();
        check("sb_drain", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
